dot_accumulator: RTL and testbench
==================================

Name: dot_accumulator

Overview:
Sits directly downstream of the fixed-point multiplier in the NPU datapath. It consumes a stream of signed Q-format products over a valid/ready handshake and accumulates one dot product at a time in a widened register with guard bits. It emits the dot product saturated back to NBITS in the same Q format, together with an overflow flag and a term count. Its output feeds the activation/writeback stage.

Parameters:
NBITS, 8, total width of products and result (signed two's complement)
DBITS, 4, fractional bits; Q format is carried through unchanged, with no shifting in this block
GBITS, 4, guard bits added to the accumulator; ACC_BITS = NBITS+GBITS
MAX_TERMS, 16, maximum products per dot product; the count reaching this value forces a close

Ports:
clk  in  1  clock, all state updates on the rising edge
rst  in  1  synchronous, active-high reset
in_val  in  1  product valid
in_rdy  out  1  block accepts a product this cycle
in_data  in  NBITS  signed product, same Q(NBITS-DBITS).DBITS format as the multiplier output
in_last  in  1  marks the final product of the current dot product; sampled only on transfer
out_val  out  1  result valid
out_rdy  in  1  consumer accepts the result
out_data  out  NBITS  saturated signed dot product
out_ovf  out  1  set if any saturation occurred, at accumulator width or at output narrowing
out_count  out  $clog2(MAX_TERMS+1)  number of products accumulated

Behaviour:
- States:
  - ACCUM: in_rdy=1, out_val=0.
  - DONE: in_rdy=0, out_val=1.
- Reset: on rst=1 at a clock edge, the block enters state ACCUM and clears acc, ovf_sticky and count.
- Reset outputs: in the cycle after reset, in_rdy=1, out_val=0, out_data=0, out_ovf=0, out_count=0.
- Reset mid-operation: the partial sum is discarded, and any pending output is dropped without a handshake.
- Input transfer: occurs when in_val && in_rdy.
  - acc is updated with a saturating add of the sign-extended in_data at ACC_BITS.
  - On saturation, acc clamps to the min or max ACC_BITS value and ovf_sticky is set.
  - count increments by 1.
- Close condition: a transfer with in_last=1, or a transfer that makes count equal MAX_TERMS, moves the state to DONE on the next edge.
- Close latency: the result is visible one cycle after the closing transfer.
- DONE outputs:
  - out_data = acc clamped to [-2^(NBITS-1), 2^(NBITS-1)-1]. This is combinational from acc, with no rounding.
  - out_ovf = ovf_sticky | (acc outside the NBITS range).
  - out_count = count.
- DONE hold: outputs remain stable while out_rdy=0, for any number of cycles.
- Output transfer: out_val && out_rdy. On the next edge the block clears acc, ovf_sticky and count and returns to ACCUM.
- Throughput: one bubble cycle per dot product; the block does not accept input while in DONE.
- In ACCUM: out_data, out_ovf and out_count are driven 0.
- in_last while in_val=0: ignored.
- Empty dot product: not possible, since at least one transfer is required to close.
- Simultaneous in_val and out_rdy while in DONE: only the output transfers; the input waits (in_rdy=0).
- X-safety: acc is updated only on a transfer; in_data is not sampled otherwise.

Decomposition:
- Shared package npu_pkg: an enum for the state (ACCUM, DONE), and helper functions sat_add(a, b) and sat_narrow(x), parameterized by width. The activation stage reuses these helpers.
- One natural sub-module: sat_adder (ACC_BITS signed saturating adder with an overflow output), instantiated once.

Test Plan:
- Basic sum: products 0x10, 0x20, 0x08 (last on the third) -> one cycle later out_val=1, out_data=0x38, out_ovf=0, out_count=3.
- Positive saturation: four products of 0x7F, last on the fourth (sum 508) -> out_data=0x7F, out_ovf=1, out_count=4.
- Negative saturation: 0x80, 0x80 with last (sum -256) -> out_data=0x80, out_ovf=1. Then 0xF0, 0x20 with last -> out_data=0x10, out_ovf=0, confirming clear-on-handshake.
- Backpressure: close a sum of 0x18 and hold out_rdy=0 for 3 cycles with in_val=1 -> in_rdy=0 and out_data=0x18 stable throughout. On out_rdy=1, the handshake completes and in_rdy=1 on the following cycle.
- MAX_TERMS auto-close: 16 products of 0x01, never asserting last -> DONE after the 16th, out_data=0x10, out_count=16. The 17th product is held off (in_rdy=0) until the output is drained.
- Reset mid-operation: accept 0x30, 0x30, assert rst for one cycle, then send 0x05 with last -> out_data=0x05, out_count=1, out_ovf=0.

Source files
------------

// File: rtl/npu_pkg.sv
// Shared NPU datapath definitions: accumulator FSM state and saturating
// arithmetic helpers that work at any width up to SAT_W (also reused by activation).
package npu_pkg;

    typedef enum logic {
        ACCUM,
        DONE
    } acc_state_t;

    localparam int unsigned SAT_W = 64;

    function automatic logic signed [SAT_W-1:0] sat_max(input int unsigned w);
        logic signed [SAT_W-1:0] one;
        one = {{(SAT_W-1){1'b0}}, 1'b1};
        return (one <<< (w - 1)) - one;
    endfunction

    function automatic logic signed [SAT_W-1:0] sat_min(input int unsigned w);
        return ~sat_max(w);
    endfunction

    // Clamp a sign-extended value into the signed range of a w-bit word.
    function automatic logic signed [SAT_W-1:0] sat_narrow(input logic signed [SAT_W-1:0] x,
                                                          input int unsigned w);
        if (x > sat_max(w)) begin
            return sat_max(w);
        end else if (x < sat_min(w)) begin
            return sat_min(w);
        end
        return x;
    endfunction

    // Operands must already lie inside the w-bit range, sign-extended to SAT_W.
    function automatic logic signed [SAT_W-1:0] sat_add(input logic signed [SAT_W-1:0] a,
                                                       input logic signed [SAT_W-1:0] b,
                                                       input int unsigned w);
        logic signed [SAT_W:0] s;
        logic signed [SAT_W-1:0] mx;
        logic signed [SAT_W-1:0] mn;
        mx = sat_max(w);
        mn = sat_min(w);
        s  = {a[SAT_W-1], a} + {b[SAT_W-1], b};
        if (s > $signed({mx[SAT_W-1], mx})) begin
            return mx;
        end else if (s < $signed({mn[SAT_W-1], mn})) begin
            return mn;
        end
        return s[SAT_W-1:0];
    endfunction

endpackage

// File: rtl/sat_adder.sv
// W-bit signed saturating adder; ovf flags that the result was clamped.
module sat_adder
    import npu_pkg::*;
#(
    parameter int unsigned W = 12
) (
    input  logic signed [W-1:0] a,
    input  logic signed [W-1:0] b,
    output logic signed [W-1:0] sum,
    output logic                ovf
);

    logic signed [SAT_W-1:0] a_x;
    logic signed [SAT_W-1:0] b_x;
    logic signed [SAT_W-1:0] sat_x;
    logic signed [SAT_W-1:0] exact_x;

    always_comb begin
        a_x     = {{(SAT_W-W){a[W-1]}}, a};
        b_x     = {{(SAT_W-W){b[W-1]}}, b};
        sat_x   = sat_add(a_x, b_x, W);
        exact_x = a_x + b_x;
        sum     = sat_x[W-1:0];
        ovf     = (sat_x != exact_x);
    end

endmodule

// File: rtl/dot_accumulator.sv
// Accumulates one signed Q-format dot product at a time with guard bits and
// emits it saturated back to NBITS, with a sticky overflow flag and term count.
module dot_accumulator
    import npu_pkg::*;
#(
    parameter int unsigned NBITS     = 8,
    parameter int unsigned DBITS     = 4,
    parameter int unsigned GBITS     = 4,
    parameter int unsigned MAX_TERMS = 16
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           in_val,
    output logic                           in_rdy,
    input  logic [NBITS-1:0]               in_data,
    input  logic                           in_last,
    output logic                           out_val,
    input  logic                           out_rdy,
    output logic [NBITS-1:0]               out_data,
    output logic                           out_ovf,
    output logic [$clog2(MAX_TERMS+1)-1:0] out_count
);

    localparam int unsigned ACC_BITS = NBITS + GBITS;
    localparam int unsigned CW       = $clog2(MAX_TERMS + 1);

    // Q format passes through untouched; only its sanity is checked here.
    if (DBITS >= NBITS) begin : g_bad_q
        $error("dot_accumulator: DBITS must be smaller than NBITS");
    end

    acc_state_t state, state_nx;

    logic signed [ACC_BITS-1:0] acc;
    logic signed [ACC_BITS-1:0] in_ext;
    logic signed [ACC_BITS-1:0] acc_sum;
    logic                       add_ovf;
    logic                       ovf_sticky;
    logic [CW-1:0]              count;
    logic [CW-1:0]              count_inc;
    logic                       in_fire;
    logic                       out_fire;
    logic                       close;
    logic signed [SAT_W-1:0]    acc_x;
    logic signed [SAT_W-1:0]    nar_x;
    logic                       nar_ovf;

    assign in_ext    = {{GBITS{in_data[NBITS-1]}}, in_data};
    assign in_fire   = in_val && in_rdy;
    assign out_fire  = out_val && out_rdy;
    assign count_inc = count + 1'b1;
    assign close     = in_fire && (in_last || (count_inc == CW'(MAX_TERMS)));

    sat_adder #(.W(ACC_BITS)) u_sat_adder (
        .a   (acc),
        .b   (in_ext),
        .sum (acc_sum),
        .ovf (add_ovf)
    );

    always_comb begin
        acc_x   = {{(SAT_W-ACC_BITS){acc[ACC_BITS-1]}}, acc};
        nar_x   = sat_narrow(acc_x, NBITS);
        nar_ovf = (nar_x != acc_x);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ACCUM;
        end else begin
            state <= state_nx;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || out_fire) begin
            acc        <= '0;
            ovf_sticky <= 1'b0;
            count      <= '0;
        end else if (in_fire) begin
            acc        <= acc_sum;
            ovf_sticky <= ovf_sticky | add_ovf;
            count      <= count_inc;
        end
    end

    always_comb begin
        state_nx  = state;
        in_rdy    = 1'b0;
        out_val   = 1'b0;
        out_data  = '0;
        out_ovf   = 1'b0;
        out_count = '0;
        case (state)
            ACCUM: begin
                in_rdy = 1'b1;
                if (close) begin
                    state_nx = DONE;
                end
            end
            DONE: begin
                out_val   = 1'b1;
                out_data  = nar_x[NBITS-1:0];
                out_ovf   = ovf_sticky | nar_ovf;
                out_count = count;
                if (out_rdy) begin
                    state_nx = ACCUM;
                end
            end
            default: state_nx = ACCUM;
        endcase
    end

endmodule

// File: tb/tb_dot_accumulator.sv
// Self-checking bench for dot_accumulator: directed cases plus random dot
// products compared against an integer-arithmetic reference model.
module tb_dot_accumulator;

    localparam int NB  = 8;
    localparam int MT  = 16;
    localparam int AMAX = 2047;
    localparam int AMIN = -2048;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_val;
    logic       in_rdy;
    logic [7:0] in_data;
    logic       in_last;
    logic       out_val;
    logic       out_rdy;
    logic [7:0] out_data;
    logic       out_ovf;
    logic [4:0] out_count;

    int total = 0;
    int bad   = 0;

    // reference model state
    int m_acc;
    bit m_ovf;
    int m_cnt;
    bit m_closed;

    always #5 clk = ~clk;

    dot_accumulator #(
        .NBITS     (NB),
        .DBITS     (4),
        .GBITS     (4),
        .MAX_TERMS (MT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_val    (in_val),
        .in_rdy    (in_rdy),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_val   (out_val),
        .out_rdy   (out_rdy),
        .out_data  (out_data),
        .out_ovf   (out_ovf),
        .out_count (out_count)
    );

    task automatic check_eq(input string tag, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic model_clear();
        m_acc    = 0;
        m_ovf    = 1'b0;
        m_cnt    = 0;
        m_closed = 1'b0;
    endtask

    // One product transfer; waits (bounded) for in_rdy, then updates the model.
    task automatic push(input logic [7:0] d, input bit last);
        int waits;
        int v;
        @(negedge clk);
        in_val  = 1'b1;
        in_data = d;
        in_last = last;
        waits   = 0;
        while (!in_rdy && waits < 50) begin
            @(negedge clk);
            waits++;
        end
        if (!in_rdy) begin
            check_eq("in_rdy_timeout", 0, 1);
            return;
        end
        v = int'($signed(d));
        m_acc = m_acc + v;
        if (m_acc > AMAX) begin
            m_acc = AMAX;
            m_ovf = 1'b1;
        end else if (m_acc < AMIN) begin
            m_acc = AMIN;
            m_ovf = 1'b1;
        end
        m_cnt++;
        if (last || m_cnt == MT) m_closed = 1'b1;
    endtask

    // Called right after the closing push; checks the result, holds, drains.
    task automatic finish_dot(input int hold, input bit keep_val);
        int exp_d;
        int exp_o;
        @(negedge clk);
        in_val  = keep_val;
        in_data = 8'h01;
        in_last = 1'b0;
        exp_d = m_acc;
        exp_o = int'(m_ovf);
        if (exp_d > 127) begin
            exp_d = 127;
            exp_o = 1;
        end else if (exp_d < -128) begin
            exp_d = -128;
            exp_o = 1;
        end
        exp_d = exp_d & 8'hFF;
        check_eq("close_out_val", int'(out_val), 1);
        for (int h = 0; h < hold; h++) begin
            check_eq("hold_in_rdy", int'(in_rdy), 0);
            check_eq("hold_out_data", int'(out_data), exp_d);
            check_eq("hold_out_count", int'(out_count), m_cnt);
            @(negedge clk);
        end
        out_rdy = 1'b1;
        check_eq("out_val", int'(out_val), 1);
        check_eq("out_data", int'(out_data), exp_d);
        check_eq("out_ovf", int'(out_ovf), exp_o);
        check_eq("out_count", int'(out_count), m_cnt);
        check_eq("done_in_rdy", int'(in_rdy), 0);
        @(negedge clk);
        out_rdy = 1'b0;
        in_val  = 1'b0;
        check_eq("drain_in_rdy", int'(in_rdy), 1);
        check_eq("drain_out_val", int'(out_val), 0);
        check_eq("drain_out_data", int'(out_data), 0);
        check_eq("drain_out_count", int'(out_count), 0);
        model_clear();
    endtask

    initial begin
        rst     = 1'b1;
        in_val  = 1'b0;
        in_data = '0;
        in_last = 1'b0;
        out_rdy = 1'b0;
        model_clear();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check_eq("rst_in_rdy", int'(in_rdy), 1);
        check_eq("rst_out_val", int'(out_val), 0);
        check_eq("rst_out_data", int'(out_data), 0);
        check_eq("rst_out_ovf", int'(out_ovf), 0);
        check_eq("rst_out_count", int'(out_count), 0);

        // basic sum 0x38
        push(8'h10, 1'b0);
        push(8'h20, 1'b0);
        push(8'h08, 1'b1);
        finish_dot(0, 1'b0);

        // positive saturation at output narrowing
        for (int i = 0; i < 4; i++) push(8'h7F, i == 3);
        finish_dot(0, 1'b0);

        // negative saturation then clear-on-handshake
        push(8'h80, 1'b0);
        push(8'h80, 1'b1);
        finish_dot(0, 1'b0);
        push(8'hF0, 1'b0);
        push(8'h20, 1'b1);
        finish_dot(0, 1'b0);

        // last without valid is ignored
        @(negedge clk);
        in_val  = 1'b0;
        in_last = 1'b1;
        @(negedge clk);
        check_eq("idle_last_out_val", int'(out_val), 0);
        in_last = 1'b0;

        // backpressure with input pending
        push(8'h08, 1'b0);
        push(8'h10, 1'b1);
        finish_dot(3, 1'b1);

        // MAX_TERMS auto-close; 17th product waits, then opens the next dot
        for (int i = 0; i < MT; i++) push(8'h01, 1'b0);
        check_eq("auto_close_model", int'(m_closed), 1);
        finish_dot(2, 1'b1);
        push(8'h01, 1'b1);
        finish_dot(0, 1'b0);

        // guard-bit saturation: 16 x 0x7F stays inside 12 bits, 16 x 0x80 does too
        for (int i = 0; i < MT; i++) push(8'h80, 1'b0);
        finish_dot(0, 1'b0);

        // reset mid-operation
        push(8'h30, 1'b0);
        push(8'h30, 1'b0);
        @(negedge clk);
        in_val = 1'b0;
        rst    = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_clear();
        check_eq("midrst_out_val", int'(out_val), 0);
        check_eq("midrst_in_rdy", int'(in_rdy), 1);
        push(8'h05, 1'b1);
        finish_dot(0, 1'b0);

        // random dot products
        for (int t = 0; t < 40; t++) begin
            int n;
            int last_at;
            n = int'($urandom_range(1, 20));
            last_at = (n > MT) ? -1 : n - 1;
            for (int i = 0; i < n && !m_closed; i++) begin
                logic [7:0] d;
                if ($urandom_range(0, 1) == 1) d = 8'($urandom_range(0, 255));
                else d = 8'($urandom_range(0, 32) - 16);
                push(d, i == last_at);
            end
            finish_dot(int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got 0 expected 1");
        $fatal(1, "simulation time limit reached");
    end

endmodule
